// File: rtl/reg_wr_arbiter.sv
// ============================================================================
//  Module      : reg_wr_arbiter
//  Description : Round-robin write arbiter that owns a shared WIDTH-bit
//                enable register. Each write goes through a GRANT -> WRITE ->
//                ACK sequence; the register holds its value otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   din,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       reg_en,
  output logic [WIDTH-1:0]           Q,
  output logic                       busy
);

  localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] c_one = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WRITE = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_idx_w-1:0]   r_win;       // winner, frozen from GRANT until IDLE
  logic [c_idx_w-1:0]   w_win_nxt;
  logic [c_idx_w-1:0]   r_last;      // most recently acknowledged requester
  logic [c_idx_w-1:0]   w_pick;
  logic [WIDTH-1:0]     r_q;
  logic [NUM_REQ-1:0]   w_win_oh;

  // Round-robin search: first active request after r_last, wrapping around.
  always_comb begin
    logic found;
    int   idx;
    w_pick = r_last;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        w_pick = c_idx_w'(idx);
        found  = 1'b1;
      end
    end
  end

  // Next-state logic; the winner is only captured when leaving IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_GRANT;
          w_win_nxt   = w_pick;
        end
      end
      // A winner that dropped its request before WRITE is abandoned.
      S_GRANT: w_state_nxt = req[r_win] ? S_WRITE : S_IDLE;
      S_WRITE: w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Winner and round-robin pointer; last starts at NUM_REQ-1 so requester 0 leads.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_win  <= '0;
      r_last <= c_idx_w'(NUM_REQ - 1);
    end else begin
      r_win <= w_win_nxt;
      if (r_state == S_ACK) begin
        r_last <= r_win;
      end
    end
  end

  // Shared register: loads the winner's data only while reg_en is high.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_q <= '0;
    end else if (reg_en) begin
      r_q <= din[r_win*WIDTH +: WIDTH];
    end
  end

  // Outputs are decoded purely from registered state.
  always_comb begin
    w_win_oh = c_one << r_win;
    gnt      = ((r_state == S_GRANT) || (r_state == S_WRITE)) ? w_win_oh : '0;
    ack      = (r_state == S_ACK) ? w_win_oh : '0;
    reg_en   = (r_state == S_WRITE);
    busy     = (r_state != S_IDLE);
    Q        = r_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_wr_arbiter.sv
// ============================================================================
//  Module      : tb_reg_wr_arbiter
//  Description : Directed self-checking bench for reg_wr_arbiter.
//                Inputs are driven and outputs sampled on falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  logic                     clk;
  logic                     RST;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] din;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic                     reg_en;
  logic [WIDTH-1:0]         Q;
  logic                     busy;

  int n_cmp;
  int n_bad;

  reg_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .RST    (RST),
    .req    (req),
    .din    (din),
    .gnt    (gnt),
    .ack    (ack),
    .reg_en (reg_en),
    .Q      (Q),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_din(input int i, input logic [WIDTH-1:0] v);
    din[i*WIDTH +: WIDTH] = v;
  endtask

  // One full successful transaction for winner w, starting at the negedge
  // where the request is already visible in IDLE. Ends in the ACK cycle.
  task automatic expect_txn(input string tag, input int w, input logic [WIDTH-1:0] data);
    logic [NUM_REQ-1:0] oh;
    oh = 4'b0001 << w;
    nxt();
    check_val({tag, "_gnt_g"},  32'(gnt),    32'(oh));
    check_val({tag, "_en_g"},   32'(reg_en), 32'd0);
    nxt();
    check_val({tag, "_gnt_w"},  32'(gnt),    32'(oh));
    check_val({tag, "_en_w"},   32'(reg_en), 32'd1);
    nxt();
    check_val({tag, "_ack"},    32'(ack),    32'(oh));
    check_val({tag, "_gnt_a"},  32'(gnt),    32'd0);
    check_val({tag, "_q"},      32'(Q),      32'(data));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    n_cmp = 0;
    n_bad = 0;

    // Reset held with all requests active and nonzero data.
    RST = 1'b1;
    req = 4'b1111;
    din = '0;
    set_din(0, 8'h10);
    set_din(1, 8'h21);
    set_din(2, 8'h32);
    set_din(3, 8'h43);
    nxt(); nxt(); nxt();
    check_val("rst_q",    32'(Q),      32'd0);
    check_val("rst_gnt",  32'(gnt),    32'd0);
    check_val("rst_ack",  32'(ack),    32'd0);
    check_val("rst_busy", 32'(busy),   32'd0);
    check_val("rst_en",   32'(reg_en), 32'd0);
    RST = 1'b0;

    // Round robin with req held: order 0,1,2,3,0, one ack every 4 cycles.
    expect_txn("rr0", 0, 8'h10);
    nxt(); check_val("rr0_idle", 32'(busy), 32'd0);
    expect_txn("rr1", 1, 8'h21);
    nxt(); check_val("rr1_idle", 32'(busy), 32'd0);
    expect_txn("rr2", 2, 8'h32);
    nxt(); check_val("rr2_idle", 32'(busy), 32'd0);
    expect_txn("rr3", 3, 8'h43);
    nxt(); check_val("rr3_idle", 32'(busy), 32'd0);
    expect_txn("rr4", 0, 8'h10);
    req = 4'b0000;
    nxt(); check_val("rr4_idle", 32'(busy), 32'd0);
    nxt();

    // Single write by requester 2; register then holds for 10 idle cycles.
    set_din(2, 8'hA5);
    req = 4'b0100;
    expect_txn("single", 2, 8'hA5);
    req = 4'b0000;
    for (int i = 0; i < 10; i++) nxt();
    check_val("hold_q",    32'(Q),    32'h0A5);
    check_val("hold_busy", 32'(busy), 32'd0);

    // Late drop: requester 3 releases req during WRITE, write still completes.
    set_din(3, 8'h3C);
    req = 4'b1000;
    nxt(); check_val("late_gnt_g", 32'(gnt), 32'b1000);
    nxt(); check_val("late_en_w",  32'(reg_en), 32'd1);
    req = 4'b0000;
    nxt();
    check_val("late_ack", 32'(ack), 32'b1000);
    check_val("late_q",   32'(Q),   32'h3C);
    nxt(); check_val("late_idle", 32'(busy), 32'd0);

    // Abort: requester 1 drops req in the GRANT cycle.
    set_din(1, 8'h11);
    req = 4'b0010;
    nxt(); check_val("abort_gnt_g", 32'(gnt), 32'b0010);
    req = 4'b0000;
    nxt();
    check_val("abort_en",   32'(reg_en), 32'd0);
    check_val("abort_ack",  32'(ack),    32'd0);
    check_val("abort_busy", 32'(busy),   32'd0);
    check_val("abort_q",    32'(Q),      32'h3C);
    nxt();
    check_val("abort_ack2", 32'(ack),    32'd0);

    // last is still 3 after the abort, so 0110 must pick requester 1.
    set_din(2, 8'h22);
    req = 4'b0110;
    expect_txn("post_abort", 1, 8'h11);
    req = 4'b0000;
    nxt();

    // Requesters 0 and 1: after last=1, scan starts at 2 and lands on 0.
    set_din(0, 8'h77);
    req = 4'b0011;
    expect_txn("pair", 0, 8'h77);
    req = 4'b0000;
    nxt();

    // Mid-write reset: asynchronous abort with no ack and Q cleared.
    set_din(2, 8'h99);
    req = 4'b0100;
    nxt(); check_val("mwr_gnt_g", 32'(gnt), 32'b0100);
    nxt(); check_val("mwr_en_w",  32'(reg_en), 32'd1);
    RST = 1'b1;
    #1;
    check_val("mwr_busy", 32'(busy),   32'd0);
    check_val("mwr_q",    32'(Q),      32'd0);
    check_val("mwr_gnt",  32'(gnt),    32'd0);
    check_val("mwr_en",   32'(reg_en), 32'd0);
    nxt();
    check_val("mwr_ack",  32'(ack),    32'd0);
    check_val("mwr_q2",   32'(Q),      32'd0);
    RST = 1'b0;
    req = 4'b1111;
    nxt(); check_val("mwr_prio", 32'(gnt), 32'b0001);
    req = 4'b0000;
    nxt(); nxt(); nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Round-robin write arbiter for a shared WIDTH-bit enable register. Up to NUM_REQ requesters compete for write access. The block sequences each write through a grant/write/acknowledge handshake and drives the register's enable and D inputs, so the register holds its value whenever no write is in progress. It sits between the requesting datapath units and the shared configuration/status register, and owns that register instance.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- WIDTH, 8: width of the shared register and of each requester's data
- clk  input  1  single clock; all state changes on its rising edge
- RST  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester write request, level-sensitive
- din  input  NUM_REQ*WIDTH  requester i's data is din[i*WIDTH +: WIDTH]
- gnt  output  NUM_REQ  one-hot grant, asserted in GRANT and WRITE
- ack  output  NUM_REQ  one-hot single-cycle acknowledge, asserted in ACK
- reg_en  output  1  enable to the shared register, high only in WRITE
- Q  output  WIDTH  shared register contents
- busy  output  1  high whenever state is not IDLE

## Operation
- Shared register behaviour: Q <= EN ? D : Q. D is din of the current winner. EN is reg_en.
- State machine (2-bit): IDLE, GRANT, WRITE, ACK.
- IDLE: if any req bit is high, pick a winner and go to GRANT. Otherwise stay in IDLE.
- Winner selection: the first requester with req high, scanning from (last+1) mod NUM_REQ upward with wrap-around. last is the index of the most recently acknowledged requester.
- GRANT: gnt[winner]=1. If req[winner] is still high, go to WRITE. If it has dropped, abort to IDLE: no write, no ack, last unchanged.
- WRITE: gnt[winner]=1 and reg_en=1. Q captures din[winner] at the end of this cycle. The write completes even if req[winner] drops during WRITE. Next state is ACK.
- ACK: ack[winner]=1 and gnt=0. last <= winner. Next state is IDLE.
- Requester contract: hold din stable from the cycle req is raised until ack is seen. Deassert req in the cycle after ack unless another write is wanted.
- Other requesters' req changes during GRANT, WRITE or ACK have no effect until the next IDLE.
- The winner index is registered on the IDLE→GRANT transition and is stable until the return to IDLE.

## Timing
- Reset (RST=1, asynchronous): state=IDLE, Q=0, gnt=0, ack=0, reg_en=0, busy=0, last=NUM_REQ-1, so requester 0 has top priority after reset. Reset wins over any clock edge.
- Reset mid-operation (any state) aborts the transaction immediately: no ack, and Q returns to 0.
- Latency: req sampled high in IDLE at edge 0, then GRANT in cycle 1, WRITE in cycle 2, ACK in cycle 3. New Q is visible in cycle 3 together with ack.
- Throughput: at most one write per 4 cycles. A back-to-back request is re-arbitrated in the IDLE cycle after ACK.
- Simultaneous requests: only one gnt bit is ever high, and gnt and ack are never high in the same cycle.
- Outputs gnt, ack, reg_en and busy are decoded from registered state only. No combinational path from req or din to any output except via Q's D path.

## Test plan
- Reset: hold RST=1 with req=4'b1111 and din nonzero. Required: Q=0, gnt=0, ack=0, busy=0. Deassert RST, then apply req=4'b1111. Required: gnt=4'b0001 first.
- Single write: req=4'b0100, din[2]=8'hA5. Required: gnt=4'b0100 in cycles 1-2, reg_en in cycle 2, ack=4'b0100 and Q=8'hA5 in cycle 3. Q holds 8'hA5 for 10 idle cycles.
- Round robin: req=4'b1111 held continuously with distinct data. Required: ack order 0,1,2,3,0. Q follows each winner's data. Each ack is 4 cycles apart.
- Abort: req=4'b0010 raised, then dropped in the GRANT cycle. Required: no reg_en, no ack, Q unchanged. Next req=4'b0011 grants requester 0, because last was not updated.
- Late drop: requester 3 drops req during WRITE. Required: write completes, ack=4'b1000, Q=din[3].
- Mid-write reset: assert RST in the WRITE cycle. Required: state IDLE, Q=0, no ack, and requester 0 has priority afterwards.
